// File: rtl/bitmap_scanout.sv
// Bitmap scan-out engine: fetches one bitmap word from the dedicated read port
// and streams it as single-bit pixels (x fastest) over a valid/ready interface.
module bitmap_scanout #(
    parameter int BMP_W  = 48,
    parameter int BMP_H  = 32,
    parameter int ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      bm_sel,
    input  logic                   abort,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [BMP_W*BMP_H-1:0] rd_q,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic                   pix_data,
    output logic [5:0]             pix_x,
    output logic [4:0]             pix_y,
    output logic                   pix_last,
    output logic                   busy,
    output logic                   done
);

    localparam int         NPIX   = BMP_W * BMP_H;
    localparam logic [5:0] X_LAST = 6'(BMP_W - 1);
    localparam logic [4:0] Y_LAST = 5'(BMP_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_STREAM
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_rdAddr;
    logic [NPIX-1:0]     r_shreg;
    logic [5:0]          r_x;
    logic [4:0]          r_y;
    logic                r_done;
    logic                w_valid;
    logic                w_xfer;
    logic                w_last;
    logic                w_launch;

    assign w_valid  = (r_state == S_STREAM);
    assign w_last   = w_valid && (r_x == X_LAST) && (r_y == Y_LAST);
    assign w_xfer   = w_valid && pix_ready;
    assign w_launch = (r_state == S_IDLE) && start && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort from any active state overrides every other transition.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_launch) w_next = S_FETCH;
            S_FETCH:  w_next = S_LOAD;
            S_LOAD:   w_next = S_STREAM;
            S_STREAM: if (w_xfer && w_last) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdAddr <= '0;
            r_shreg  <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_xfer && w_last && !abort;
            if (w_launch) begin
                r_rdAddr <= bm_sel;
            end
            if ((r_state == S_LOAD) && !abort) begin
                r_shreg <= rd_q;
                r_x     <= '0;
                r_y     <= '0;
            end else if (w_xfer && !abort) begin
                r_shreg <= {1'b0, r_shreg[NPIX-1:1]};
                // x wraps only at the row end; y saturates on the final row.
                if (r_x == X_LAST) begin
                    r_x <= '0;
                    if (r_y != Y_LAST) begin
                        r_y <= r_y + 5'd1;
                    end
                end else begin
                    r_x <= r_x + 6'd1;
                end
            end
        end
    end

    assign rd_addr   = r_rdAddr;
    assign pix_valid = w_valid;
    assign pix_data  = r_shreg[0];
    assign pix_x     = r_x;
    assign pix_y     = r_y;
    assign pix_last  = w_last;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_bitmap_scanout.sv
// Self-checking bench for bitmap_scanout: single-bit table vectors, randomized
// back-pressure scans against a pixel-index model, abort and reset sequences.
`timescale 1ns/1ps
module tb_bitmap_scanout;

    localparam int BMP_W  = 48;
    localparam int BMP_H  = 32;
    localparam int ADDR_W = 3;
    localparam int NPIX   = BMP_W * BMP_H;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              pix_ready = 1'b0;
    logic [ADDR_W-1:0] bm_sel = '0;
    logic [ADDR_W-1:0] rd_addr;
    logic [NPIX-1:0]   rd_q;
    logic              pix_valid;
    logic              pix_data;
    logic [5:0]        pix_x;
    logic [4:0]        pix_y;
    logic              pix_last;
    logic              busy;
    logic              done;

    logic [NPIX-1:0]   mem [8];

    int testsRun    = 0;
    int testsFailed = 0;

    int nXfer, nDone, pixErr, stabErr, rdErr, ones, oneX, oneY;
    int doneCycle, firstValid, afterAbortBusy, timedOut;

    typedef struct {
        int bitIdx;
        int sel;
        int expX;
        int expY;
    } vec_t;

    vec_t vecs [6];

    bitmap_scanout #(.BMP_W(BMP_W), .BMP_H(BMP_H), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bm_sel    (bm_sel),
        .abort     (abort),
        .rd_addr   (rd_addr),
        .rd_q      (rd_q),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_last  (pix_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Bitmap memory with one cycle of registered read latency.
    always @(posedge clk) rd_q <= mem[rd_addr];

    task automatic checkOutput(input string name, input longint act, input longint exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fillRandom(input int sel);
        logic [NPIX-1:0] w;
        for (int i = 0; i < NPIX / 32; i++) w[i*32 +: 32] = $urandom();
        mem[sel] = w;
    endtask

    // abortMode: 0 none, 1 abort driven after edge abortAt, 2 abort on the final transfer.
    task automatic applyStimulus(input int sel, input bit randReady, input int abortMode,
                                 input int abortAt, input int restartAt);
        logic [NPIX-1:0] w;
        logic [12:0]     bundle;
        logic [12:0]     prevBundle;
        logic            prevValid;
        logic            prevReady;
        int              k;
        int              abortEdge;
        nXfer = 0; nDone = 0; pixErr = 0; stabErr = 0; rdErr = 0; ones = 0;
        oneX = -1; oneY = -1; doneCycle = 0; firstValid = 0; afterAbortBusy = -1;
        timedOut = 1;
        w = mem[sel];
        k = 0;
        abortEdge = 0;
        prevValid = 1'b0;
        prevReady = 1'b0;
        prevBundle = '0;
        @(negedge clk);
        start = 1'b1;
        bm_sel = 3'(sel);
        abort = 1'b0;
        pix_ready = 1'b0;
        for (int n = 1; n <= 8000; n++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            bm_sel = 3'($urandom());
            if (n == restartAt) begin
                start = 1'b1;
                bm_sel = 3'(sel) ^ 3'd1;
            end
            if (rd_addr !== 3'(sel)) rdErr++;
            if (done === 1'b1) begin
                nDone++;
                doneCycle = n;
            end
            if (n == abortEdge) afterAbortBusy = ((busy !== 1'b0) || (pix_valid !== 1'b0)) ? 1 : 0;
            bundle = {pix_data, pix_x, pix_y, pix_last};
            if (prevValid && !prevReady && ((pix_valid !== 1'b1) || (bundle !== prevBundle))) stabErr++;
            if ((pix_valid === 1'b1) && (firstValid == 0)) firstValid = n;
            if (pix_valid === 1'b1) begin
                if (k >= NPIX) pixErr++;
                else if ((pix_x !== 6'(k % BMP_W)) || (pix_y !== 5'(k / BMP_W)) ||
                         (pix_data !== w[k]) || (pix_last !== (k == NPIX - 1))) pixErr++;
            end
            pix_ready = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
            if ((abortMode == 1) && (n == abortAt)) begin
                abort = 1'b1;
                abortEdge = n + 1;
            end
            if ((abortMode == 2) && (pix_valid === 1'b1) && (pix_last === 1'b1) && pix_ready) begin
                abort = 1'b1;
                abortEdge = n + 1;
            end
            if ((pix_valid === 1'b1) && pix_ready && !abort) begin
                nXfer++;
                k++;
                if (pix_data === 1'b1) begin
                    ones++;
                    oneX = int'(pix_x);
                    oneY = int'(pix_y);
                end
            end
            prevValid = (pix_valid === 1'b1) && !abort;
            prevReady = pix_ready;
            prevBundle = bundle;
            if ((nDone > 0) && (n >= doneCycle + 2)) begin
                timedOut = 0;
                break;
            end
            if ((abortEdge > 0) && (n >= abortEdge + 3)) begin
                timedOut = 0;
                break;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        pix_ready = 1'b0;
    endtask

    task automatic checkFullScan(input string tag, input bit exactTiming);
        checkOutput({tag, " timeout"}, timedOut, 0);
        checkOutput({tag, " pixels"}, pixErr, 0);
        checkOutput({tag, " stall stability"}, stabErr, 0);
        checkOutput({tag, " rd_addr"}, rdErr, 0);
        checkOutput({tag, " transfers"}, nXfer, NPIX);
        checkOutput({tag, " done pulses"}, nDone, 1);
        if (exactTiming) begin
            checkOutput({tag, " first valid cycle"}, firstValid, 3);
            checkOutput({tag, " done cycle"}, doneCycle, 1539);
        end
    endtask

    // Reset state, table vectors, random back-pressure, start-while-busy, aborts, mid-scan reset.
    initial begin
        logic [18:0] outs;
        int          doneSeen;
        for (int i = 0; i < 8; i++) mem[i] = '0;

        vecs[0] = '{bitIdx: 0,    sel: 3, expX: 0,  expY: 0};
        vecs[1] = '{bitIdx: 48,   sel: 1, expX: 0,  expY: 1};
        vecs[2] = '{bitIdx: 47,   sel: 6, expX: 47, expY: 0};
        vecs[3] = '{bitIdx: 1535, sel: 7, expX: 47, expY: 31};
        vecs[4] = '{bitIdx: 100,  sel: 0, expX: 4,  expY: 2};
        vecs[5] = '{bitIdx: 775,  sel: 5, expX: 7,  expY: 16};

        repeat (3) @(negedge clk);
        outs = {rd_addr, pix_valid, pix_data, pix_x, pix_y, pix_last, busy, done};
        checkOutput("reset outputs", $isunknown(outs) ? -1 : longint'(outs), 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle busy after reset", longint'(busy), 0);

        for (int v = 0; v < 6; v++) begin
            mem[vecs[v].sel] = '0;
            mem[vecs[v].sel][vecs[v].bitIdx] = 1'b1;
            applyStimulus(vecs[v].sel, 1'b0, 0, 0, 0);
            checkFullScan($sformatf("vec%0d", v), 1'b1);
            checkOutput($sformatf("vec%0d ones", v), ones, 1);
            checkOutput($sformatf("vec%0d one x", v), oneX, vecs[v].expX);
            checkOutput($sformatf("vec%0d one y", v), oneY, vecs[v].expY);
        end

        for (int r = 0; r < 3; r++) begin
            int sel;
            sel = $urandom_range(0, 7);
            fillRandom(sel);
            applyStimulus(sel, 1'b1, 0, 0, (r == 1) ? 200 : 0);
            checkFullScan($sformatf("rand%0d", r), 1'b0);
        end

        fillRandom(2);
        applyStimulus(2, 1'b0, 1, 1, 0);
        checkOutput("abort fetch timeout", timedOut, 0);
        checkOutput("abort fetch idle", afterAbortBusy, 0);
        checkOutput("abort fetch done", nDone, 0);
        checkOutput("abort fetch transfers", nXfer, 0);
        applyStimulus(2, 1'b0, 0, 0, 0);
        checkFullScan("after fetch abort", 1'b1);

        fillRandom(4);
        applyStimulus(4, 1'b0, 2, 0, 0);
        checkOutput("abort last timeout", timedOut, 0);
        checkOutput("abort last idle", afterAbortBusy, 0);
        checkOutput("abort last done", nDone, 0);
        checkOutput("abort last transfers", nXfer, NPIX - 1);
        checkOutput("abort last pixels", pixErr, 0);
        applyStimulus(4, 1'b0, 0, 0, 0);
        checkFullScan("after last abort", 1'b1);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        bm_sel = 3'd6;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start with abort busy", longint'(busy), 0);
        checkOutput("start with abort rd_addr", longint'(rd_addr), 4);

        fillRandom(5);
        @(negedge clk);
        start = 1'b1;
        bm_sel = 3'd5;
        @(negedge clk);
        start = 1'b0;
        pix_ready = 1'b1;
        repeat (100) @(negedge clk);
        checkOutput("mid stream valid", longint'(pix_valid & busy), 1);
        #2 rst_n = 1'b0;
        #1;
        outs = {rd_addr, pix_valid, pix_data, pix_x, pix_y, pix_last, busy, done};
        checkOutput("async reset outputs", $isunknown(outs) ? -1 : longint'(outs), 0);
        doneSeen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) doneSeen++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (done !== 1'b0) doneSeen++;
        checkOutput("reset no done", doneSeen, 0);
        checkOutput("reset idle busy", longint'(busy), 0);
        pix_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
